// File: rtl/axi_mem_responder.sv
// AXI4 far-end memory target: the write engine (AW/W -> B) and the read engine (AR -> R)
// run independently and share one byte-enabled RAM.
module axi_mem_responder #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awlock,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic [3:0]              awqos,
    input  logic [3:0]              awregion,
    input  logic                    awuser,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wuser,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    buser,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic [3:0]              arqos,
    input  logic [3:0]              arregion,
    input  logic                    aruser,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    ruser,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int DB       = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(DB);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    // Encodings happen to order by severity, so "worst" is a plain max.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (ADDR_LSB + DEPTH_LOG2)) != '0;
    endfunction

    function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
        return burst[1] || (int'(size) > ADDR_LSB);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        return (burst == 2'b01) ? a + (ADDR_WIDTH'(1) << size) : a;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, awqos, awregion, awuser,
                             arlock, arcache, arprot, arqos, arregion, aruser, wid, wuser};
    assign buser = 1'b0;
    assign ruser = 1'b0;

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    wstate_t                 ws;
    logic [ID_WIDTH-1:0]     w_id;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [7:0]              w_len, w_cnt;
    logic [2:0]              w_size;
    logic [1:0]              w_burst, w_err;
    logic                    w_bad;

    logic                    w_fire, w_dec, w_final, w_we;
    logic [1:0]              w_beat_err;
    logic [DEPTH_LOG2-1:0]   w_idx;

    assign w_fire     = wvalid && wready;
    assign w_dec      = out_of_range(w_addr);
    assign w_final    = (w_cnt == w_len);
    assign w_we       = w_fire && !w_bad && !w_dec;
    assign w_idx      = w_addr[ADDR_LSB +: DEPTH_LOG2];
    // A misplaced wlast is flagged but the beat still lands; only the count ends the burst.
    assign w_beat_err = worst(w_err, worst(w_dec ? DECERR : OKAY,
                                           (wlast != w_final) ? SLVERR : OKAY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ws <= W_IDLE;
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
            bid <= '0; bresp <= OKAY;
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
            w_size <= '0; w_burst <= '0; w_err <= OKAY; w_bad <= 1'b0;
        end else begin
            case (ws)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id <= awid; w_addr <= awaddr; w_len <= awlen;
                        w_size <= awsize; w_burst <= awburst; w_cnt <= '0;
                        w_bad <= bad_burst(awsize, awburst);
                        w_err <= bad_burst(awsize, awburst) ? SLVERR : OKAY;
                        awready <= 1'b0;
                        wready <= 1'b1;
                        ws <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_err  <= w_beat_err;
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_final) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= w_id;
                            bresp  <= w_beat_err;
                            ws     <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        ws      <= W_IDLE;
                    end
                end
                default: ws <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < DB; b++)
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    // ---------------- read engine ----------------
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
    rstate_t                 rs;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len, r_cnt;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_bad, r_dec;
    logic [DEPTH_LOG2-1:0]   r_idx;

    assign r_dec = out_of_range(r_addr);
    assign r_idx = r_addr[ADDR_LSB +: DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs <= R_IDLE;
            arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
            rid <= '0; rdata <= '0; rresp <= OKAY;
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0;
            r_size <= '0; r_burst <= '0; r_bad <= 1'b0;
        end else begin
            case (rs)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_id <= arid; r_addr <= araddr; r_len <= arlen;
                        r_size <= arsize; r_burst <= arburst; r_cnt <= '0;
                        r_bad <= bad_burst(arsize, arburst);
                        arready <= 1'b0;
                        rs <= R_FETCH;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    // Registered RAM read; same-cycle writes land after this sample.
                    rdata  <= (r_bad || r_dec) ? '0 : mem[r_idx];
                    rresp  <= r_dec ? DECERR : (r_bad ? SLVERR : OKAY);
                    rlast  <= (r_cnt == r_len);
                    rid    <= r_id;
                    rvalid <= 1'b1;
                    rs     <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        if (rlast) begin
                            arready <= 1'b1;
                            rs      <= R_IDLE;
                        end else begin
                            r_addr <= next_addr(r_addr, r_size, r_burst);
                            r_cnt  <= r_cnt + 8'd1;
                            rs     <= R_FETCH;
                        end
                    end
                end
                default: rs <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder against a byte-array memory model.
module tb_axi_mem_responder;
    localparam int IW = 16, AW = 64, DW = 512, DB = 64, DL = 10;
    localparam logic [AW-1:0] LIMIT = AW'(DB) << DL;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [IW-1:0] awid, arid, wid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock, awuser, aruser, wuser, buser, ruser;
    logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0] wdata, rdata;
    logic [DB-1:0] wstrb;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];

    logic [DW-1:0] model [1 << DL];
    logic [DW-1:0] wd [256];
    logic [DB-1:0] wsb [256];

    int errors = 0, checks = 0;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // response sinks: random backpressure, or forced patterns for directed cases
    bit b_hold = 0, r_tog = 0;
    initial begin
        bready = 1'b0; rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bready = b_hold ? 1'b0 : ($urandom_range(3) != 0);
            rready = r_tog ? !rready : ($urandom_range(2) != 0);
        end
    end

    // monitor: pops expectations on each handshake, checks R stability under stall
    bexp_t be;
    rexp_t re;
    logic r_hold = 1'b0, h_last;
    logic [DW-1:0] h_data;
    logic [1:0] h_resp;
    always @(negedge clk) begin
        if (!rst_n) r_hold = 1'b0;
        else begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: bid=%0h bresp=%0h with nothing expected", bid, bresp);
                end else begin
                    be = bq.pop_front();
                    chk("bid", DW'(bid), DW'(be.id));
                    chk("bresp", DW'(bresp), DW'(be.resp));
                end
            end
            if (r_hold) begin
                chk("rvalid_held", DW'(rvalid), DW'(1));
                if (rvalid) begin
                    chk("rdata_stable", rdata, h_data);
                    chk("rresp_stable", DW'(rresp), DW'(h_resp));
                    chk("rlast_stable", DW'(rlast), DW'(h_last));
                end
            end
            r_hold = 1'b0;
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: rid=%0h rdata=%0h with nothing expected", rid, rdata);
                end else begin
                    re = rq.pop_front();
                    chk("rid", DW'(rid), DW'(re.id));
                    chk("rdata", rdata, re.data);
                    chk("rresp", DW'(rresp), DW'(re.resp));
                    chk("rlast", DW'(rlast), DW'(re.last));
                end
            end else if (rvalid) begin
                r_hold = 1'b1; h_data = rdata; h_resp = rresp; h_last = rlast;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // bad_last: beat index whose wlast is inverted (-1 for a well-formed burst)
    task automatic issue_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                               input int size, input logic [1:0] burst, input int bad_last);
        logic [AW-1:0] a;
        logic [1:0] resp;
        bit bad;
        int n;
        bad  = (burst >= 2'd2) || ((1 << size) > DB);
        resp = bad ? 2'd2 : 2'd0;
        a    = addr;
        for (int i = 0; i <= len; i++) begin
            if (a >= LIMIT) resp = 2'd3;
            else if (!bad)
                for (int b = 0; b < DB; b++)
                    if (wsb[i][b]) model[int'(a / AW'(DB))][b*8 +: 8] = wd[i][b*8 +: 8];
            if (i == bad_last && resp == 2'd0) resp = 2'd2;
            if (burst == 2'b01) a = a + (AW'(1) << size);
        end
        bq.push_back({id, resp});

        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin cyc(1); n++; end
        chk("aw_handshake", DW'(awready), DW'(1));
        cyc(1);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            cyc($urandom_range(1));
            wvalid = 1'b1; wdata = wd[i]; wstrb = wsb[i];
            wlast = (i == len) ^ (i == bad_last);
            n = 0;
            while (!wready && n < 100) begin cyc(1); n++; end
            chk("w_handshake", DW'(wready), DW'(1));
            cyc(1);
            wvalid = 1'b0; wlast = 1'b0;
        end
    endtask

    task automatic issue_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                              input int size, input logic [1:0] burst, input bit lat);
        logic [AW-1:0] a;
        logic [1:0] resp;
        logic [DW-1:0] d;
        bit bad;
        int n;
        bad = (burst >= 2'd2) || ((1 << size) > DB);
        a   = addr;
        for (int i = 0; i <= len; i++) begin
            resp = bad ? 2'd2 : 2'd0;
            d    = '0;
            if (a >= LIMIT) resp = 2'd3;
            else if (!bad) d = model[int'(a / AW'(DB))];
            rq.push_back({id, d, resp, i == len});
            if (burst == 2'b01) a = a + (AW'(1) << size);
        end
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin cyc(1); n++; end
        chk("ar_handshake", DW'(arready), DW'(1));
        cyc(1);
        arvalid = 1'b0;
        if (lat) begin
            chk("rvalid_at_T+1", DW'(rvalid), DW'(0));
            cyc(1);
            chk("rvalid_at_T+2", DW'(rvalid), DW'(1));
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (bq.size() != 0 && n < 2000) begin cyc(1); n++; end
        chk("b_outstanding", DW'(bq.size()), DW'(0));
    endtask

    task automatic wait_r();
        int n = 0;
        while (rq.size() != 0 && n < 2000) begin cyc(1); n++; end
        chk("r_outstanding", DW'(rq.size()), DW'(0));
    endtask

    task automatic rand_shape(output int len, output int size, output logic [1:0] burst,
                              output logic [AW-1:0] addr, input int wbase, input int wspan);
        int r;
        len = $urandom_range(15);
        r = $urandom_range(9);
        size = (r == 0) ? 7 : (r < 3) ? $urandom_range(5) : 6;
        r = $urandom_range(19);
        burst = (r == 0) ? 2'b10 : (r < 4) ? 2'b00 : 2'b01;
        addr = AW'((wbase + $urandom_range(wspan - 1)) * DB + (($urandom_range(DB - 1) >> size) << size));
        if ($urandom_range(15) == 0) addr = addr | (AW'(1) << $urandom_range(63, 16));
    endtask

    task automatic rand_write(input int wbase, input int wspan);
        int len, size, bl;
        logic [1:0] burst;
        logic [AW-1:0] addr;
        rand_shape(len, size, burst, addr, wbase, wspan);
        bl = ($urandom_range(9) == 0) ? $urandom_range(len) : -1;
        for (int i = 0; i <= len; i++) begin
            wd[i]  = rnd_data();
            wsb[i] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : '1;
        end
        issue_write(IW'($urandom), addr, len, size, burst, bl);
        wait_b();
    endtask

    task automatic rand_read(input int wbase, input int wspan);
        int len, size;
        logic [1:0] burst;
        logic [AW-1:0] addr;
        rand_shape(len, size, burst, addr, wbase, wspan);
        issue_read(IW'($urandom), addr, len, size, burst, 1'b0);
        wait_r();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {awid, awaddr, awlen, awsize, awburst, awvalid, awlock, awcache, awprot, awqos, awregion, awuser} = '0;
        {arid, araddr, arlen, arsize, arburst, arvalid, arlock, arcache, arprot, arqos, arregion, aruser} = '0;
        {wid, wdata, wstrb, wlast, wuser, wvalid} = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", DW'({awready, wready, bvalid, arready, rvalid, rlast, bid, rid, bresp, rresp}), '0);
        chk("reset_rdata", rdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_ready", DW'({awready, arready, bvalid, rvalid}), '0);
        cyc(1);
        chk("ready_after_release", DW'({awready, arready}), DW'(2'b11));

        // preload words 0..63 so every later read hits known contents
        for (int i = 0; i < 64; i++) begin wd[i] = rnd_data(); wsb[i] = '1; end
        issue_write(16'h0001, '0, 63, 6, 2'b01, -1); wait_b();

        for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); wsb[i] = '1; end
        issue_write(16'h1234, 64'h40, 3, 6, 2'b01, -1); wait_b();
        issue_read(16'h0abc, 64'h40, 3, 6, 2'b01, 1'b1); wait_r();

        wd[0] = '0; wsb[0] = '1;
        issue_write(16'h0002, '0, 0, 6, 2'b01, -1); wait_b();
        wd[0] = '1; wsb[0] = 64'h1;
        issue_write(16'h0003, '0, 0, 6, 2'b01, -1); wait_b();
        issue_read(16'h0004, '0, 0, 6, 2'b01, 1'b0); wait_r();

        wd[0] = rnd_data(); wsb[0] = '1;
        issue_write(16'h0005, AW'(1) << 16, 0, 6, 2'b01, -1); wait_b();
        issue_read(16'h0006, AW'(1) << 16, 1, 6, 2'b01, 1'b0); wait_r();
        issue_read(16'h0007, '0, 0, 6, 2'b01, 1'b0); wait_r();

        for (int i = 0; i < 4; i++) begin wd[i] = rnd_data(); wsb[i] = '1; end
        issue_write(16'h0008, 64'h80, 1, 6, 2'b10, -1); wait_b();
        issue_read(16'h0009, 64'h80, 1, 6, 2'b01, 1'b0); wait_r();
        issue_write(16'h000a, 64'h100, 1, 6, 2'b01, 0); wait_b();
        issue_write(16'h000b, 64'h140, 2, 6, 2'b01, 2); wait_b();
        issue_read(16'h000c, 64'h100, 3, 6, 2'b01, 1'b0); wait_r();

        for (int i = 0; i < 4; i++) begin wd[i] = rnd_data(); wsb[i] = {$urandom, $urandom}; end
        issue_write(16'h000d, 64'hC0, 3, 6, 2'b00, -1); wait_b();
        issue_read(16'h000e, 64'hC0, 2, 6, 2'b00, 1'b0); wait_r();
        issue_write(16'h000f, 64'h200, 1, 7, 2'b01, -1); wait_b();
        issue_read(16'h0010, 64'h200, 1, 7, 2'b01, 1'b0); wait_r();

        r_tog = 1;
        issue_read(16'h0011, 64'h40, 3, 6, 2'b01, 1'b0); wait_r();
        r_tog = 0;

        b_hold = 1;
        for (int i = 0; i < 2; i++) begin wd[i] = rnd_data(); wsb[i] = '1; end
        issue_write(16'h0012, 64'h240, 1, 6, 2'b01, -1);
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_held", DW'(bvalid), DW'(1));
            chk("awready_while_b", DW'(awready), DW'(0));
            cyc(1);
        end
        b_hold = 0;
        wait_b();

        // reset in the middle of a read burst
        issue_read(16'h0013, '0, 7, 6, 2'b01, 1'b0);
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        chk("rvalid_after_reset", DW'(rvalid), DW'(0));
        chk("arready_in_reset", DW'(arready), DW'(0));
        rq.delete();
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_first_edge", DW'(arready), DW'(0));
        cyc(1);
        chk("arready_after_reset", DW'(arready), DW'(1));
        issue_read(16'h0014, '0, 7, 6, 2'b01, 1'b0); wait_r();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2))
                0: rand_write(0, 16);
                1: rand_read(0, 48);
                default: fork
                    rand_write(0, 16);
                    rand_read(32, 16);
                join
            endcase
        end

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
